idma_reg64_job_driver: RTL and testbench

Register-bus initiator that programs and launches transfers on the iDMA 64-bit register frontend, acting as the control-side counterpart of the DMA's register slave. It accepts one transfer descriptor (src, dst, length, decouple/burst configuration) on a valid/ready stream. It then issues the 32-bit register writes, reads `NEXT_ID` to launch and capture the transfer ID, and polls `DONE_ID` until the transfer retires. On retirement it returns a completion record. It sits between a local controller (test sequencer or management core) and the `axi_to_reg`-fronted DMA configuration port.

---
 rtl/idma_job_drv_pkg.sv | 51 +++++
 rtl/idma_reg64_job_driver.sv | 197 +++++++++++++++++++
 tb/tb_idma_reg64_job_driver.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idma_job_drv_pkg.sv
// Shared definitions for the iDMA 64-bit register-frontend job driver.
//   - Register offsets inside the DMA register block.
//   - state_e : job-driver FSM states.
//   - job_t   : latched transfer descriptor (src/dst zero-extended to 64 bits).
//   - idma_reg_req_t / idma_reg_rsp_t : default register-bus request/response
//     types (64-bit address, 32-bit data).
package idma_job_drv_pkg;

  localparam logic [7:0] OFF_SRC     = 8'h00;
  localparam logic [7:0] OFF_DST     = 8'h08;
  localparam logic [7:0] OFF_LEN     = 8'h10;
  localparam logic [7:0] OFF_CONF    = 8'h18;
  localparam logic [7:0] OFF_NEXT_ID = 8'h28;
  localparam logic [7:0] OFF_DONE_ID = 8'h30;

  typedef enum logic [3:0] {
    IDLE,
    WR_SRC_LO,
    WR_SRC_HI,
    WR_DST_LO,
    WR_DST_HI,
    WR_LEN,
    WR_CONF,
    RD_NEXT,
    POLL_WAIT,
    RD_DONE,
    CPL
  } state_e;

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
    logic [31:0] len;
    logic [31:0] conf;
  } job_t;

  typedef struct packed {
    logic [63:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } idma_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } idma_reg_rsp_t;

endpackage

// File: rtl/idma_reg64_job_driver.sv
// Register-bus initiator that programs one iDMA transfer through the 64-bit
// register frontend, launches it by reading NEXT_ID, polls DONE_ID until the
// transfer retires and then returns a completion record.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   job_src_i/dst_i/len_i/conf_i  transfer descriptor
//   job_valid_i / job_ready_o     descriptor handshake (ready only in IDLE)
//   cpl_id_o, cpl_err_o           completion record (retired ID, error flag)
//   cpl_valid_o / cpl_ready_i     completion handshake
//   reg_req_o / reg_rsp_i         register bus request / response
//   busy_o                        high whenever a job is in progress
module idma_reg64_job_driver
  import idma_job_drv_pkg::*;
#(
  parameter int unsigned          AddrWidth = 64,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0,
  parameter int unsigned          IdWidth   = 32,
  parameter int unsigned          PollGap   = 4,
  parameter type                  reg_req_t = idma_reg_req_t,
  parameter type                  reg_rsp_t = idma_reg_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] job_src_i,
  input  logic [AddrWidth-1:0] job_dst_i,
  input  logic [31:0]          job_len_i,
  input  logic [31:0]          job_conf_i,
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  output logic [IdWidth-1:0]   cpl_id_o,
  output logic                 cpl_err_o,
  output logic                 cpl_valid_o,
  input  logic                 cpl_ready_i,
  output reg_req_t             reg_req_o,
  input  reg_rsp_t             reg_rsp_i,
  output logic                 busy_o
);

  localparam int unsigned       CntW    = (PollGap > 1) ? $clog2(PollGap) : 1;
  localparam logic [CntW-1:0]   GapLast = CntW'((PollGap > 0) ? PollGap - 1 : 0);
  // With no poll gap the FSM skips POLL_WAIT entirely.
  localparam state_e            PollEntry = (PollGap == 0) ? RD_DONE : POLL_WAIT;

  state_e               state_q, state_d;
  job_t                 job_q, job_d;
  logic [IdWidth-1:0]   launch_id_q, launch_id_d;
  logic [CntW-1:0]      poll_cnt_q, poll_cnt_d;
  reg_req_t             reg_req_q, reg_req_d;
  logic                 cpl_valid_q, cpl_valid_d;
  logic [IdWidth-1:0]   cpl_id_q, cpl_id_d;
  logic                 cpl_err_q, cpl_err_d;

  logic                 acc_done;
  logic [IdWidth-1:0]   id_diff;
  logic [7:0]           req_off;
  logic [31:0]          req_wdata;
  logic                 req_write;
  logic                 req_valid;

  assign acc_done = reg_req_q.valid & reg_rsp_i.ready;
  // Wrap-aware retirement: DONE_ID has reached launch_id when the modular
  // difference lies in the lower half of the ID space.
  assign id_diff  = reg_rsp_i.rdata[IdWidth-1:0] - launch_id_q;

  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    launch_id_d = launch_id_q;
    poll_cnt_d  = poll_cnt_q;
    cpl_valid_d = cpl_valid_q;
    cpl_id_d    = cpl_id_q;
    cpl_err_d   = cpl_err_q;

    unique case (state_q)
      IDLE: begin
        if (job_valid_i) begin
          job_d                    = '0;
          job_d.src[AddrWidth-1:0] = job_src_i;
          job_d.dst[AddrWidth-1:0] = job_dst_i;
          job_d.len                = job_len_i;
          job_d.conf               = job_conf_i;
          launch_id_d              = '0;
          poll_cnt_d               = '0;
          state_d                  = WR_SRC_LO;
        end
      end
      WR_SRC_LO: if (acc_done) state_d = WR_SRC_HI;
      WR_SRC_HI: if (acc_done) state_d = WR_DST_LO;
      WR_DST_LO: if (acc_done) state_d = WR_DST_HI;
      WR_DST_HI: if (acc_done) state_d = WR_LEN;
      WR_LEN:    if (acc_done) state_d = WR_CONF;
      WR_CONF:   if (acc_done) state_d = RD_NEXT;
      RD_NEXT: begin
        if (acc_done) begin
          launch_id_d = reg_rsp_i.rdata[IdWidth-1:0];
          state_d     = PollEntry;
        end
      end
      POLL_WAIT: begin
        if (poll_cnt_q == GapLast) begin
          poll_cnt_d = '0;
          state_d    = RD_DONE;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
      RD_DONE: begin
        if (acc_done) begin
          if (!id_diff[IdWidth-1]) begin
            state_d     = CPL;
            cpl_valid_d = 1'b1;
            cpl_id_d    = launch_id_q;
            cpl_err_d   = 1'b0;
          end else begin
            state_d = PollEntry;
          end
        end
      end
      CPL: begin
        if (cpl_ready_i) begin
          cpl_valid_d = 1'b0;
          cpl_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An error on any accepted access aborts the job; launch_id_q is still 0
    // if the failing access was the launch read itself.
    if (acc_done && reg_rsp_i.error) begin
      state_d     = CPL;
      cpl_valid_d = 1'b1;
      cpl_err_d   = 1'b1;
      cpl_id_d    = launch_id_q;
    end
  end

  // The request is decoded from the next state so that it is available from
  // a flop in the same cycle the FSM enters an access state.
  always_comb begin
    req_off   = '0;
    req_wdata = '0;
    req_write = 1'b0;
    req_valid = 1'b1;
    unique case (state_d)
      WR_SRC_LO: begin req_off = OFF_SRC;          req_wdata = job_d.src[31:0];  req_write = 1'b1; end
      WR_SRC_HI: begin req_off = OFF_SRC + 8'd4;   req_wdata = job_d.src[63:32]; req_write = 1'b1; end
      WR_DST_LO: begin req_off = OFF_DST;          req_wdata = job_d.dst[31:0];  req_write = 1'b1; end
      WR_DST_HI: begin req_off = OFF_DST + 8'd4;   req_wdata = job_d.dst[63:32]; req_write = 1'b1; end
      WR_LEN:    begin req_off = OFF_LEN;          req_wdata = job_d.len;        req_write = 1'b1; end
      WR_CONF:   begin req_off = OFF_CONF;         req_wdata = job_d.conf;       req_write = 1'b1; end
      RD_NEXT:   req_off = OFF_NEXT_ID;
      RD_DONE:   req_off = OFF_DONE_ID;
      default:   req_valid = 1'b0;
    endcase

    reg_req_d = '0;
    if (req_valid) begin
      reg_req_d.addr  = BaseAddr + AddrWidth'(req_off);
      reg_req_d.write = req_write;
      reg_req_d.wdata = req_wdata;
      reg_req_d.wstrb = 4'hF;
      reg_req_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      job_q       <= '0;
      launch_id_q <= '0;
      poll_cnt_q  <= '0;
      reg_req_q   <= '0;
      cpl_valid_q <= 1'b0;
      cpl_id_q    <= '0;
      cpl_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      launch_id_q <= launch_id_d;
      poll_cnt_q  <= poll_cnt_d;
      reg_req_q   <= reg_req_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_id_q    <= cpl_id_d;
      cpl_err_q   <= cpl_err_d;
    end
  end

  assign reg_req_o   = reg_req_q;
  assign cpl_valid_o = cpl_valid_q;
  assign cpl_id_o    = cpl_id_q;
  assign cpl_err_o   = cpl_err_q;
  assign job_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_idma_reg64_job_driver.sv
// Bench for idma_reg64_job_driver: a register-slave model with configurable
// wait states, error injection and NEXT_ID/DONE_ID read data, plus a job-level
// reference model that predicts the access list, idle gaps, latency and the
// completion record of every job.
module tb_idma_reg64_job_driver;
  import idma_job_drv_pkg::*;

  localparam int          POLL_GAP = 4;
  localparam logic [63:0] BASE     = 64'h0000_0000_A000_0000;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [63:0]   job_src_i = '0, job_dst_i = '0;
  logic [31:0]   job_len_i = '0, job_conf_i = '0;
  logic          job_valid_i = 1'b0;
  logic          job_ready_o;
  logic [31:0]   cpl_id_o;
  logic          cpl_err_o, cpl_valid_o;
  logic          cpl_ready_i = 1'b0;
  idma_reg_req_t reg_req_o;
  idma_reg_rsp_t reg_rsp_i = '0;
  logic          busy_o;

  always #5 clk = ~clk;

  idma_reg64_job_driver #(
    .AddrWidth (64),
    .BaseAddr  (BASE),
    .IdWidth   (32),
    .PollGap   (POLL_GAP),
    .reg_req_t (idma_reg_req_t),
    .reg_rsp_t (idma_reg_rsp_t)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .job_src_i   (job_src_i),
    .job_dst_i   (job_dst_i),
    .job_len_i   (job_len_i),
    .job_conf_i  (job_conf_i),
    .job_valid_i (job_valid_i),
    .job_ready_o (job_ready_o),
    .cpl_id_o    (cpl_id_o),
    .cpl_err_o   (cpl_err_o),
    .cpl_valid_o (cpl_valid_o),
    .cpl_ready_i (cpl_ready_i),
    .reg_req_o   (reg_req_o),
    .reg_rsp_i   (reg_rsp_i),
    .busy_o      (busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle counter: value k after the k-th rising edge.
  int cyc = 0;
  int hs_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_ni && job_valid_i && job_ready_o) hs_cyc <= cyc + 1;
  end

  // ---------------- register slave model ----------------
  int            acc_idx = 0, err_idx = -1, wait_mode = 0, cur_wait = 0, wcnt = 0;
  int            stab_err = 0, start_c = 0;
  logic [31:0]   next_id = '0;
  logic [31:0]   done_q[$];
  idma_reg_req_t first_req;
  logic [63:0]   log_addr[$];
  logic          log_wr[$];
  logic [31:0]   log_wdata[$];
  logic [3:0]    log_wstrb[$];
  int            log_start[$], log_acc[$];

  always @(negedge clk) begin
    reg_rsp_i = '0;
    if (!rst_ni) begin
      wcnt = 0;
    end else if (reg_req_o.valid) begin
      if (wcnt == 0) begin
        first_req = reg_req_o;
        start_c   = cyc;
        cur_wait  = (wait_mode == 0) ? 0 : (wait_mode == 1) ? 3 : int'($urandom_range(0, 3));
      end else if (reg_req_o != first_req) begin
        stab_err++;
      end
      if (wcnt == cur_wait) begin
        reg_rsp_i.ready = 1'b1;
        reg_rsp_i.error = (acc_idx == err_idx);
        if (!reg_req_o.write) begin
          if (reg_req_o.addr == BASE + 64'h28) reg_rsp_i.rdata = next_id;
          else if (done_q.size() > 0)          reg_rsp_i.rdata = done_q.pop_front();
          else                                 reg_rsp_i.rdata = next_id;
        end
        log_addr.push_back(reg_req_o.addr);
        log_wr.push_back(reg_req_o.write);
        log_wdata.push_back(reg_req_o.wdata);
        log_wstrb.push_back(reg_req_o.wstrb);
        log_start.push_back(start_c);
        log_acc.push_back(cyc + 1);
        acc_idx++;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else if (wcnt != 0) begin
      // request withdrawn before it was accepted
      stab_err++;
      wcnt = 0;
    end
  end

  task automatic clear_slave(input int mode, input int eidx);
    log_addr.delete(); log_wr.delete(); log_wdata.delete(); log_wstrb.delete();
    log_start.delete(); log_acc.delete();
    acc_idx = 0; err_idx = eidx; wait_mode = mode; stab_err = 0;
  endtask

  // ---------------- one job, fully checked ----------------
  task automatic run_job(input string name, input logic [63:0] src, input logic [63:0] dst,
                         input logic [31:0] len, input logic [31:0] conf, input logic [31:0] nid,
                         input int mode, input int eidx, input int hold);
    logic [63:0] exp_addr[$];
    logic        exp_wr[$];
    logic [31:0] exp_wd[$];
    logic [31:0] dq[$];
    logic [31:0] exp_id;
    logic        exp_err;
    int          n_done, total, n_exp, t, bad, lim, gap;

    // model: number of DONE_ID reads until the first retired value
    dq = done_q;
    n_done = dq.size() + 1;
    for (int i = 0; i < dq.size(); i++) begin
      if (32'(dq[i] - nid) < 32'h8000_0000) begin n_done = i + 1; break; end
    end
    exp_addr = '{BASE + 64'h00, BASE + 64'h04, BASE + 64'h08, BASE + 64'h0C, BASE + 64'h10, BASE + 64'h18, BASE + 64'h28};
    exp_wr   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_wd   = '{src[31:0], src[63:32], dst[31:0], dst[63:32], len, conf, 32'h0};
    for (int i = 0; i < n_done; i++) begin
      exp_addr.push_back(BASE + 64'h30); exp_wr.push_back(1'b0); exp_wd.push_back(32'h0);
    end
    total   = 7 + n_done;
    n_exp   = total;
    exp_id  = nid;
    exp_err = 1'b0;
    if (eidx >= 0 && eidx < total) begin
      n_exp   = eidx + 1;
      exp_err = 1'b1;
      exp_id  = (eidx >= 7) ? nid : 32'h0;
    end

    clear_slave(mode, eidx);
    next_id = nid;

    @(negedge clk);
    job_src_i = src; job_dst_i = dst; job_len_i = len; job_conf_i = conf;
    job_valid_i = 1'b1;
    t = 0;
    while (!job_ready_o && t < 200) begin @(negedge clk); t++; end
    if (!job_ready_o) begin
      check_val({name, "_hs_timeout"}, 0, 1);
      job_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    job_valid_i = 1'b0;
    check_val({name, "_hs_ready"}, job_ready_o, 0);
    check_val({name, "_hs_busy"}, busy_o, 1);

    t = 0;
    while (!cpl_valid_o && t < 3000) begin @(negedge clk); t++; end
    if (!cpl_valid_o) begin
      check_val({name, "_cpl_timeout"}, 0, 1);
      return;
    end
    check_val({name, "_cpl_id"}, cpl_id_o, exp_id);
    check_val({name, "_cpl_err"}, cpl_err_o, exp_err);
    if (mode == 0 && !exp_err)
      check_val({name, "_latency"}, cyc - hs_cyc, 7 + n_done * (POLL_GAP + 1));

    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (cpl_valid_o !== 1'b1 || cpl_id_o !== exp_id || cpl_err_o !== exp_err ||
          job_ready_o !== 1'b0 || reg_req_o.valid !== 1'b0) bad++;
    end
    if (hold > 0) check_val({name, "_cpl_hold"}, bad, 0);
    cpl_ready_i = 1'b1;
    @(negedge clk);
    cpl_ready_i = 1'b0;
    check_val({name, "_cpl_release"}, {cpl_valid_o, job_ready_o, busy_o, cpl_err_o}, 4'b0100);

    check_val({name, "_n_acc"}, log_addr.size(), n_exp);
    lim = (log_addr.size() < n_exp) ? log_addr.size() : n_exp;
    for (int i = 0; i < lim; i++) begin
      check_val($sformatf("%s_addr%0d", name, i), log_addr[i], exp_addr[i]);
      check_val($sformatf("%s_wr%0d", name, i), log_wr[i], exp_wr[i]);
      check_val($sformatf("%s_wstrb%0d", name, i), log_wstrb[i], 4'hF);
      if (exp_wr[i]) check_val($sformatf("%s_wdata%0d", name, i), log_wdata[i], exp_wd[i]);
      if (i > 0) begin
        gap = (exp_addr[i] == BASE + 64'h30) ? POLL_GAP : 0;
        check_val($sformatf("%s_gap%0d", name, i), log_start[i] - log_acc[i-1], gap);
      end
    end
    check_val({name, "_req_stable"}, stab_err, 0);
    $display("job %s: src=0x%0h dst=0x%0h len=0x%0h nid=0x%0h mode=%0d eidx=%0d -> id=0x%0h err=%0b accesses=%0d",
             name, src, dst, len, nid, mode, eidx, cpl_id_o, cpl_err_o, log_addr.size());
  endtask

  task automatic check_reset_outputs(input string name);
    check_val({name, "_req"}, reg_req_o, '0);
    check_val({name, "_flags"}, {job_ready_o, busy_o, cpl_valid_o, cpl_err_o}, 4'b1000);
    check_val({name, "_cpl_id"}, cpl_id_o, 0);
  endtask

  initial begin
    int t, nb, e;
    logic [31:0] nid;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    @(negedge clk);

    // basic zero-wait job
    done_q = '{32'd5};
    run_job("basic", 64'h1_0000_1000, 64'h8000_0000, 32'h40, 32'h0, 32'd5, 0, -1, 0);

    // three polls before retirement
    done_q = '{32'd4, 32'd4, 32'd5};
    run_job("poll3", 64'h2_0000_0040, 64'h3_0000_0080, 32'h100, 32'h5, 32'd5, 0, -1, 0);

    // slave delays every access by 3 cycles
    done_q = '{32'h11, 32'h12};
    run_job("wait3", 64'hDEAD_BEEF_0000_1000, 64'h0123_4567_89AB_CDEF, 32'h1234, 32'hA5A5_0001, 32'h12, 1, -1, 0);

    // error on the length write
    done_q = '{32'd9};
    run_job("err_len", 64'h10, 64'h20, 32'h30, 32'h1, 32'd9, 0, 4, 0);

    // completion back-pressure
    done_q = '{32'd77};
    run_job("hold10", 64'h4000, 64'h5000, 32'h80, 32'h2, 32'd77, 0, -1, 10);

    // ID wrap-around
    done_q = '{32'hFFFF_FFFE, 32'h0};
    run_job("wrap", 64'h6000, 64'h7000, 32'h8, 32'h0, 32'hFFFF_FFFF, 0, -1, 0);

    // reset in the middle of the DST_HI write
    clear_slave(1, -1);
    @(negedge clk);
    job_src_i = 64'h9000; job_dst_i = 64'hA000; job_len_i = 32'h10; job_conf_i = 32'h0;
    job_valid_i = 1'b1;
    @(negedge clk);
    job_valid_i = 1'b0;
    t = 0;
    while (!(reg_req_o.valid && reg_req_o.addr == BASE + 64'h0C) && t < 200) begin @(negedge clk); t++; end
    check_val("mid_reach_dst_hi", reg_req_o.addr, BASE + 64'h0C);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    check_reset_outputs("mid_reset_hold");
    #2 rst_ni = 1'b1;
    $display("job mid_reset: reset during DST_HI write, outputs returned to reset values");

    done_q = '{32'h3};
    run_job("post_reset", 64'hB000, 64'hC000, 32'h44, 32'h0, 32'h3, 0, -1, 0);

    // randomized jobs
    for (int j = 0; j < 12; j++) begin
      nid = $urandom;
      done_q.delete();
      nb = int'($urandom_range(0, 3));
      for (int k = 0; k < nb; k++) done_q.push_back(nid - $urandom_range(1, 1000));
      done_q.push_back(nid + $urandom_range(0, 1000));
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_job($sformatf("rand%0d", j), {$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom,
              nid, int'($urandom_range(0, 2)), e, int'($urandom_range(0, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
